// File: rtl/interrupt_controller_if.sv
// Interrupt request/dispatch bundle between sources, pipeline control and
// the interrupt controller (master = sources/pipeline, slave = controller).
interface interrupt_controller_if #(
  parameter int N_CH = 4
) ();
  localparam int VEC_W = $clog2(N_CH);

  logic [N_CH-1:0]  INT_IN;
  logic [N_CH-1:0]  MASK;
  logic             Stall;
  logic             ACK;
  logic             INT_OUT;
  logic [VEC_W-1:0] INT_VEC;
  logic [N_CH-1:0]  PENDING;
  logic             BUSY;

  modport master (
    output INT_IN,
    output MASK,
    output Stall,
    output ACK,
    input  INT_OUT,
    input  INT_VEC,
    input  PENDING,
    input  BUSY
  );

  modport slave (
    input  INT_IN,
    input  MASK,
    input  Stall,
    input  ACK,
    output INT_OUT,
    output INT_VEC,
    output PENDING,
    output BUSY
  );
endinterface

// File: rtl/interrupt_controller.sv
// Multi-channel interrupt controller: edge detect, pending latch, masked
// fixed-priority dispatch (lowest index wins), stall-frozen INT_OUT pulse,
// then wait for ACK. Ports: clk, reset (sync, active-low), bus (slave):
// INT_IN/MASK/Stall/ACK in, INT_OUT/INT_VEC/PENDING/BUSY out.
module interrupt_controller #(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int VEC_W       = $clog2(N_CH)
) (
  input logic                   clk,
  input logic                   reset,
  interrupt_controller_if.slave bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    WAIT_ACK
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N_CH-1:0]  prev_q;
  logic [N_CH-1:0]  pend_q;
  logic [N_CH-1:0]  pend_d;
  logic [N_CH-1:0]  evt;
  logic [N_CH-1:0]  elig;
  logic [N_CH-1:0]  clr;
  logic [VEC_W-1:0] sel;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] vec_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             int_out_q;

  assign evt  = bus.INT_IN & ~prev_q;
  assign elig = pend_q & bus.MASK;

  // Scan downward so the lowest eligible index is the last write.
  always_comb begin
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (elig[i]) sel = VEC_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        vec_d = '0;
        if ((|elig) && !bus.Stall) begin
          state_d = ASSERT;
          vec_d   = sel;
          cnt_d   = '0;
          clr     = N_CH'(1) << sel;
        end
      end
      ASSERT: begin
        if (!bus.Stall) begin
          if (cnt_q == LAST) state_d = WAIT_ACK;
          else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (bus.ACK) begin
          state_d = IDLE;
          vec_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        vec_d   = '0;
        cnt_d   = '0;
      end
    endcase
    // A fresh edge on the bit being dispatched keeps it pending.
    pend_d = (pend_q & ~clr) | evt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      prev_q    <= bus.INT_IN;
      pend_q    <= '0;
      vec_q     <= '0;
      cnt_q     <= '0;
      int_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= bus.INT_IN;
      pend_q    <= pend_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      int_out_q <= (state_d == ASSERT);
    end
  end

  assign bus.INT_OUT = int_out_q;
  assign bus.INT_VEC = vec_q;
  assign bus.PENDING = pend_q;
  assign bus.BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed vector table, hand sequences for
// stall freeze and mid-operation reset, then random stimulus vs a model.
module tb_interrupt_controller;

  localparam int N = 4;
  localparam int H = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  interrupt_controller_if #(.N_CH(N)) bus ();

  interrupt_controller #(
    .N_CH(N),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: an interrupt is "in service" for H unstalled cycles of
  // output, then awaits ACK; pending is a plain bitset.
  logic [N-1:0] m_prev;
  logic [N-1:0] m_pend;
  int m_svc;
  int m_left;
  bit m_wait;

  function automatic void model_step(bit r, logic [N-1:0] i,
                                     logic [N-1:0] m, bit s, bit a);
    logic [N-1:0] ev;
    int pick;
    if (!r) begin
      m_prev = i;
      m_pend = '0;
      m_svc = -1;
      m_left = 0;
      m_wait = 0;
      return;
    end
    ev = i & ~m_prev;
    m_prev = i;
    pick = -1;
    for (int k = 0; k < N; k++)
      if (pick < 0 && m_pend[k] && m[k]) pick = k;
    if (m_svc >= 0 && !m_wait) begin
      if (!s) begin
        m_left--;
        if (m_left == 0) m_wait = 1;
      end
    end else if (m_svc >= 0) begin
      if (a) begin
        m_svc = -1;
        m_wait = 0;
      end
    end else if (pick >= 0 && !s) begin
      m_svc = pick;
      m_left = H;
      m_pend[pick] = 1'b0;
    end
    m_pend = m_pend | ev;
  endfunction

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic cycle(int r, int i, int m, int s, int a);
    reset = (r != 0);
    bus.INT_IN = N'(i);
    bus.MASK = N'(m);
    bus.Stall = (s != 0);
    bus.ACK = (a != 0);
    @(posedge clk);
    model_step(r != 0, N'(i), N'(m), s != 0, a != 0);
    #1;
  endtask

  typedef struct {
    int rst, in, mask, st, ack;
    int out, vec, pend, busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(int r, int i, int m, int s, int a,
                     int o, int v, int p, int b);
    vec_t e;
    e.rst = r; e.in = i; e.mask = m; e.st = s; e.ack = a;
    e.out = o; e.vec = v; e.pend = p; e.busy = b;
    tbl.push_back(e);
  endtask

  task automatic chk_all(string tag, int o, int v, int p, int b);
    chk({tag, " out"}, int'(bus.INT_OUT), o);
    chk({tag, " vec"}, int'(bus.INT_VEC), v);
    chk({tag, " pend"}, int'(bus.PENDING), p);
    chk({tag, " busy"}, int'(bus.BUSY), b);
  endtask

  initial begin
    int hi;
    bit done;
    logic [N-1:0] rin;
    logic [N-1:0] rmask;

    bus.INT_IN = '0;
    bus.MASK = '0;
    bus.Stall = 1'b0;
    bus.ACK = 1'b0;

    // reset with INT_IN[0] held high, then re-raise
    add(0, 4'b0001, 4'hf, 0, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b0001, 4'hf, 0, 0, 0, 0, 4'b0000, 0);
    add(1, 4'b0001, 4'hf, 0, 0, 0, 0, 4'b0000, 0);
    add(1, 4'b0001, 4'hf, 0, 0, 0, 0, 4'b0000, 0);
    add(1, 4'b0000, 4'hf, 0, 0, 0, 0, 4'b0000, 0);
    add(1, 4'b0001, 4'hf, 0, 0, 0, 0, 4'b0001, 0);
    add(1, 4'b0001, 4'hf, 0, 0, 1, 0, 4'b0000, 1);
    add(1, 4'b0001, 4'hf, 0, 0, 1, 0, 4'b0000, 1);
    add(1, 4'b0001, 4'hf, 0, 0, 0, 0, 4'b0000, 1);
    add(1, 4'b0001, 4'hf, 0, 1, 0, 0, 4'b0000, 0);
    // priority: channels 3 and 1 together
    add(1, 4'b1011, 4'hf, 0, 0, 0, 0, 4'b1010, 0);
    add(1, 4'b1011, 4'hf, 0, 0, 1, 1, 4'b1000, 1);
    add(1, 4'b1011, 4'hf, 0, 0, 1, 1, 4'b1000, 1);
    add(1, 4'b1011, 4'hf, 0, 0, 0, 1, 4'b1000, 1);
    add(1, 4'b1011, 4'hf, 0, 1, 0, 0, 4'b1000, 0);
    add(1, 4'b1011, 4'hf, 0, 0, 1, 3, 4'b0000, 1);
    add(1, 4'b1011, 4'hf, 0, 0, 1, 3, 4'b0000, 1);
    add(1, 4'b1011, 4'hf, 0, 0, 0, 3, 4'b0000, 1);
    add(1, 4'b1011, 4'hf, 0, 1, 0, 0, 4'b0000, 0);
    // mask holds channel 1 pending until unmasked
    add(1, 4'b0000, 4'hd, 0, 0, 0, 0, 4'b0000, 0);
    add(1, 4'b0010, 4'hd, 0, 0, 0, 0, 4'b0010, 0);
    add(1, 4'b0010, 4'hd, 0, 0, 0, 0, 4'b0010, 0);
    add(1, 4'b0010, 4'hf, 0, 0, 1, 1, 4'b0000, 1);
    add(1, 4'b0010, 4'hf, 0, 0, 1, 1, 4'b0000, 1);
    add(1, 4'b0010, 4'hf, 0, 0, 0, 1, 4'b0000, 1);
    add(1, 4'b0010, 4'hf, 0, 1, 0, 0, 4'b0000, 0);
    // set wins over dispatch clear on channel 2
    add(1, 4'b0110, 4'hf, 0, 0, 0, 0, 4'b0100, 0);
    add(1, 4'b0010, 4'hf, 1, 0, 0, 0, 4'b0100, 0);
    add(1, 4'b0110, 4'hf, 0, 0, 1, 2, 4'b0100, 1);
    add(1, 4'b0110, 4'hf, 0, 0, 1, 2, 4'b0100, 1);
    add(1, 4'b0110, 4'hf, 0, 0, 0, 2, 4'b0100, 1);
    add(1, 4'b0110, 4'hf, 0, 1, 0, 0, 4'b0100, 0);
    add(1, 4'b0110, 4'hf, 0, 0, 1, 2, 4'b0000, 1);
    add(1, 4'b0110, 4'hf, 0, 0, 1, 2, 4'b0000, 1);
    add(1, 4'b0110, 4'hf, 0, 0, 0, 2, 4'b0000, 1);
    add(1, 4'b0110, 4'hf, 0, 1, 0, 0, 4'b0000, 0);

    foreach (tbl[k]) begin
      cycle(tbl[k].rst, tbl[k].in, tbl[k].mask, tbl[k].st, tbl[k].ack);
      chk_all($sformatf("row%0d", k), tbl[k].out, tbl[k].vec,
              tbl[k].pend, tbl[k].busy);
    end

    // stall freeze: 3 stalled cycles from the first INT_OUT cycle
    cycle(1, 4'b0000, 4'hf, 0, 0);
    cycle(1, 4'b0001, 4'hf, 0, 0);
    cycle(1, 4'b0001, 4'hf, 0, 0);
    chk("stall first_out", int'(bus.INT_OUT), 1);
    hi = 1;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle(1, 4'b0001, 4'hf, (k < 3) ? 1 : 0, 0);
      if (bus.INT_OUT) hi++;
      else done = 1;
    end
    chk("stall fell", int'(done), 1);
    chk("stall out_cycles", hi, 5);
    chk("stall wait_busy", int'(bus.BUSY), 1);
    cycle(1, 4'b0001, 4'hf, 0, 1);
    chk_all("stall ack", 0, 0, 4'b0000, 0);

    // reset during ASSERT with channel 0 pending
    cycle(1, 4'b0000, 4'hf, 0, 0);
    cycle(1, 4'b0010, 4'hf, 0, 0);
    cycle(1, 4'b0010, 4'hf, 0, 0);
    chk_all("midrst svc", 1, 1, 4'b0000, 1);
    cycle(1, 4'b0011, 4'hf, 0, 0);
    chk_all("midrst pend", 1, 1, 4'b0001, 1);
    cycle(0, 4'b0011, 4'hf, 0, 0);
    chk_all("midrst rst", 0, 0, 4'b0000, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 4'b0011, 4'hf, 0, 0);
      chk_all($sformatf("midrst after%0d", k), 0, 0, 4'b0000, 0);
    end

    // randomized against the model
    rin = 4'b0011;
    rmask = 4'hf;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(2) == 0) rin ^= N'(1 << $urandom_range(N - 1));
      if ($urandom_range(15) == 0) rmask = N'($urandom);
      cycle(($urandom_range(79) == 0) ? 0 : 1, int'(rin), int'(rmask),
            ($urandom_range(3) == 0) ? 1 : 0,
            ($urandom_range(2) == 0) ? 1 : 0);
      chk_all($sformatf("rnd%0d", k),
              (m_svc >= 0 && !m_wait) ? 1 : 0,
              (m_svc >= 0) ? m_svc : 0,
              int'(m_pend),
              (m_svc >= 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
